mips_cpu: RTL and testbench

MIPS_CPU -- requirements
Module: mips_cpu

---
 rtl/mips_pkg.sv | 63 ++++++
 rtl/instr_mem.sv | 23 ++
 rtl/mips_cpu.sv | 211 +++++++++++++++++++++
 tb/tb_mips_cpu.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings, ALU operations and pipeline-register layouts for the
// five-stage MIPS subset core.
package mips_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2a;

  localparam logic [31:0] NopInstr = 32'h0000_0000;

  typedef enum logic [2:0] {AluAdd, AluSub, AluAnd, AluOr, AluSlt} alu_op_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } if_id_t;

  typedef struct packed {
    alu_op_e     alu_op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [31:0] pc4;
    logic        use_imm;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
    logic        is_beq;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] st_data;
    logic [4:0]  rd;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        reg_we;
  } mem_wb_t;

  localparam if_id_t  IfIdNop  = '{instr: NopInstr, pc4: 32'h0};
  localparam id_ex_t  IdExNop  = '0;
  localparam ex_mem_t ExMemNop = '0;
  localparam mem_wb_t MemWbNop = '0;

endpackage

// File: rtl/instr_mem.sv
// Instruction memory: combinational word read, optional clocked load port
// (tied off in the core; the array is normally filled through hierarchy).
module instr_mem #(
  parameter int unsigned Words = 2048,
  parameter int unsigned Aw    = $clog2(Words)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [Aw-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [Aw-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] data [0:Words-1];

  always_ff @(posedge clk_i) begin
    if (we_i) data[waddr_i] <= wdata_i;
  end

  assign rdata_o = data[raddr_i];

endmodule

// File: rtl/mips_cpu.sv
// Five-stage in-order MIPS subset core. Define MIPS_FORWARD_EN to enable
// EX/MEM and MEM/WB operand forwarding; otherwise ID stalls on RAW hazards.
module mips_cpu
  import mips_pkg::*;
#(
  parameter int unsigned IM_WORDS = 2048,
  parameter int unsigned DM_WORDS = 1024
) (
  input logic clk,
  input logic reset_b
);

  localparam int unsigned ImAw = $clog2(IM_WORDS);
  localparam int unsigned DmAw = $clog2(DM_WORDS);

  logic [31:0] pc_if, pc_d, instr_if;
  if_id_t      if_id_q, if_id_d;
  id_ex_t      id_ex_q, id_ex_d, id_dec;
  ex_mem_t     ex_mem_q, ex_mem_d;
  mem_wb_t     mem_wb_q, mem_wb_d;
  logic [31:0] rf_q   [32];
  logic [31:0] dmem_q [DM_WORDS];

  instr_mem #(
    .Words(IM_WORDS)
  ) IM (
    .clk_i  (clk),
    .we_i   (1'b0),
    .waddr_i('0),
    .wdata_i('0),
    .raddr_i(pc_if[2 +: ImAw]),
    .rdata_o(instr_if)
  );

  // ---------------- ID ----------------
  logic [5:0]  id_op, id_fn;
  logic [4:0]  id_rs, id_rt;
  logic        uses_rs, uses_rt, is_j, stall, hit_ex;
  logic [31:0] rs_val, rt_val, j_target;

  assign id_op    = if_id_q.instr[31:26];
  assign id_fn    = if_id_q.instr[5:0];
  assign id_rs    = if_id_q.instr[25:21];
  assign id_rt    = if_id_q.instr[20:16];
  assign j_target = {if_id_q.pc4[31:28], if_id_q.instr[25:0], 2'b00};

  // Write-before-read: the WB result is visible to this cycle's ID read.
  always_comb begin
    rs_val = rf_q[id_rs];
    rt_val = rf_q[id_rt];
    if (mem_wb_q.reg_we && mem_wb_q.rd == id_rs) rs_val = mem_wb_q.wdata;
    if (mem_wb_q.reg_we && mem_wb_q.rd == id_rt) rt_val = mem_wb_q.wdata;
  end

  always_comb begin
    id_dec        = IdExNop;
    id_dec.rs     = id_rs;
    id_dec.rt     = id_rt;
    id_dec.rs_val = rs_val;
    id_dec.rt_val = rt_val;
    id_dec.imm    = {{16{if_id_q.instr[15]}}, if_id_q.instr[15:0]};
    id_dec.pc4    = if_id_q.pc4;
    uses_rs       = 1'b0;
    uses_rt       = 1'b0;
    is_j          = 1'b0;
    case (id_op)
      OpRtype: begin
        id_dec.rd     = if_id_q.instr[15:11];
        id_dec.reg_we = 1'b1;
        uses_rs       = 1'b1;
        uses_rt       = 1'b1;
        case (id_fn)
          FnAdd:   id_dec.alu_op = AluAdd;
          FnSub:   id_dec.alu_op = AluSub;
          FnAnd:   id_dec.alu_op = AluAnd;
          FnOr:    id_dec.alu_op = AluOr;
          FnSlt:   id_dec.alu_op = AluSlt;
          default: begin
            id_dec.reg_we = 1'b0;
            uses_rs       = 1'b0;
            uses_rt       = 1'b0;
          end
        endcase
      end
      OpAddi, OpLw: begin
        id_dec.rd      = id_rt;
        id_dec.reg_we  = 1'b1;
        id_dec.use_imm = 1'b1;
        id_dec.mem_re  = (id_op == OpLw);
        uses_rs        = 1'b1;
      end
      OpSw: begin
        id_dec.use_imm = 1'b1;
        id_dec.mem_we  = 1'b1;
        uses_rs        = 1'b1;
        uses_rt        = 1'b1;
      end
      OpBeq: begin
        id_dec.is_beq = 1'b1;
        uses_rs       = 1'b1;
        uses_rt       = 1'b1;
      end
      OpJ:     is_j = 1'b1;
      default: ;
    endcase
    // Writes to $0 are dropped here, so neither hazard nor forwarding logic sees them.
    if (id_dec.rd == 5'd0) id_dec.reg_we = 1'b0;
  end

  assign hit_ex = id_ex_q.reg_we && ((uses_rs && id_ex_q.rd == id_rs) ||
                                     (uses_rt && id_ex_q.rd == id_rt));
`ifdef MIPS_FORWARD_EN
  assign stall = hit_ex && id_ex_q.mem_re;
`else
  logic hit_mem;
  assign hit_mem = ex_mem_q.reg_we && ((uses_rs && ex_mem_q.rd == id_rs) ||
                                       (uses_rt && ex_mem_q.rd == id_rt));
  assign stall   = hit_ex || hit_mem;
`endif

  // ---------------- EX ----------------
  logic [31:0] op_a, op_b, alu_b, alu_res, br_target;
  logic        br_taken;

  always_comb begin
    op_a = id_ex_q.rs_val;
    op_b = id_ex_q.rt_val;
`ifdef MIPS_FORWARD_EN
    if (ex_mem_q.reg_we && ex_mem_q.rd == id_ex_q.rs)      op_a = ex_mem_q.alu_res;
    else if (mem_wb_q.reg_we && mem_wb_q.rd == id_ex_q.rs) op_a = mem_wb_q.wdata;
    if (ex_mem_q.reg_we && ex_mem_q.rd == id_ex_q.rt)      op_b = ex_mem_q.alu_res;
    else if (mem_wb_q.reg_we && mem_wb_q.rd == id_ex_q.rt) op_b = mem_wb_q.wdata;
`endif
    alu_b = id_ex_q.use_imm ? id_ex_q.imm : op_b;
    case (id_ex_q.alu_op)
      AluSub:  alu_res = op_a - alu_b;
      AluAnd:  alu_res = op_a & alu_b;
      AluOr:   alu_res = op_a | alu_b;
      AluSlt:  alu_res = {31'd0, $signed(op_a) < $signed(alu_b)};
      default: alu_res = op_a + alu_b;
    endcase
  end

  assign br_taken  = id_ex_q.is_beq && (op_a == op_b);
  assign br_target = id_ex_q.pc4 + {id_ex_q.imm[29:0], 2'b00};

  always_comb begin
    ex_mem_d.alu_res = alu_res;
    ex_mem_d.st_data = op_b;
    ex_mem_d.rd      = id_ex_q.rd;
    ex_mem_d.reg_we  = id_ex_q.reg_we;
    ex_mem_d.mem_re  = id_ex_q.mem_re;
    ex_mem_d.mem_we  = id_ex_q.mem_we;
  end

  // ---------------- MEM ----------------
  always_comb begin
    mem_wb_d.rd     = ex_mem_q.rd;
    mem_wb_d.reg_we = ex_mem_q.reg_we;
    mem_wb_d.wdata  = ex_mem_q.mem_re ? dmem_q[ex_mem_q.alu_res[2 +: DmAw]] : ex_mem_q.alu_res;
  end

  // Redirect priority: taken branch in EX, then load/RAW stall, then jump in ID.
  always_comb begin
    pc_d          = pc_if + 32'd4;
    if_id_d.instr = instr_if;
    if_id_d.pc4   = pc_if + 32'd4;
    id_ex_d       = id_dec;
    if (br_taken) begin
      pc_d    = br_target;
      if_id_d = IfIdNop;
      id_ex_d = IdExNop;
    end else if (stall) begin
      pc_d    = pc_if;
      if_id_d = if_id_q;
      id_ex_d = IdExNop;
    end else if (is_j) begin
      pc_d    = j_target;
      if_id_d = IfIdNop;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_b) begin
      pc_if    <= '0;
      if_id_q  <= IfIdNop;
      id_ex_q  <= IdExNop;
      ex_mem_q <= ExMemNop;
      mem_wb_q <= MemWbNop;
    end else begin
      pc_if    <= pc_d;
      if_id_q  <= if_id_d;
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_b) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (mem_wb_q.reg_we) begin
      rf_q[mem_wb_q.rd] <= mem_wb_q.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_b && ex_mem_q.mem_we) dmem_q[ex_mem_q.alu_res[2 +: DmAw]] <= ex_mem_q.st_data;
  end

endmodule

// File: tb/tb_mips_cpu.sv
// Directed bench for mips_cpu: hand-assembled programs with hand-computed
// register, memory and pc_if expectations (stall counts depend on MIPS_FORWARD_EN).
module tb_mips_cpu;

  localparam logic [5:0] TOpR = 6'h00, TOpJ = 6'h02, TOpBeq = 6'h04;
  localparam logic [5:0] TOpAddi = 6'h08, TOpLw = 6'h23, TOpSw = 6'h2b;
  localparam logic [5:0] TFnAdd = 6'h20, TFnSub = 6'h22, TFnAnd = 6'h24;
  localparam logic [5:0] TFnOr = 6'h25, TFnSlt = 6'h2a;

`ifdef MIPS_FORWARD_EN
  localparam int RawStalls = 0;
  localparam int LuStalls  = 1;
`else
  localparam int RawStalls = 4;
  localparam int LuStalls  = 4;
`endif

  logic clk = 1'b0;
  logic reset_b = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   edges;
  logic [31:0] prog [0:31];
  logic [31:0] max_pc;
  logic [31:0] exp_regs [0:15];

  always #5 clk = ~clk;

  mips_cpu #(
    .IM_WORDS(2048),
    .DM_WORDS(1024)
  ) dut (
    .clk    (clk),
    .reset_b(reset_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {TOpR, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_and_reset(input int n);
    reset_b = 1'b1;
    for (int i = 0; i < 2048; i++) dut.IM.data[i] = (i < n) ? prog[i] : 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_b = 1'b0;
  endtask

  task automatic run_until_pc(input logic [31:0] target, input int budget, output int n);
    n = 0;
    while (dut.pc_if !== target && n < budget) begin
      step();
      n++;
    end
  endtask

  initial begin
    // Reset with IM all NOP, then a linear pc_if walk.
    reset_b = 1'b1;
    for (int i = 0; i < 2048; i++) dut.IM.data[i] = 32'h0;
    repeat (10) @(posedge clk);
    #1;
    check("reset_pc", dut.pc_if, 32'h0);
    check("reset_rf", dut.rf_q[7], 32'h0);
    @(negedge clk);
    reset_b = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      check("nop_pc_walk", dut.pc_if, 32'(4 * i));
    end

    // RAW chain.
    prog[0] = i_ins(TOpAddi, 5'd0, 5'd1, 16'd5);
    prog[1] = i_ins(TOpAddi, 5'd1, 5'd2, 16'd7);
    prog[2] = r_ins(TFnAdd, 5'd1, 5'd2, 5'd3);
    load_and_reset(3);
    run_until_pc(32'h20, 40, edges);
    check("raw_edges", 32'(edges), 32'(8 + RawStalls));
    repeat (8) step();
    check("raw_r2", dut.rf_q[2], 32'd12);
    check("raw_r3", dut.rf_q[3], 32'd17);

    // Store, load, load-use.
    prog[0] = i_ins(TOpAddi, 5'd0, 5'd3, 16'd17);
    prog[1] = i_ins(TOpSw, 5'd0, 5'd3, 16'd8);
    prog[2] = i_ins(TOpLw, 5'd0, 5'd4, 16'd8);
    prog[3] = r_ins(TFnAdd, 5'd4, 5'd4, 5'd5);
    load_and_reset(4);
    run_until_pc(32'h20, 40, edges);
    check("lu_edges", 32'(edges), 32'(8 + LuStalls));
    repeat (8) step();
    check("lu_dmem2", dut.dmem_q[2], 32'd17);
    check("lu_r4", dut.rf_q[4], 32'd17);
    check("lu_r5", dut.rf_q[5], 32'd34);

    // Taken beq skips two instructions.
    prog[0] = i_ins(TOpBeq, 5'd0, 5'd0, 16'd2);
    prog[1] = i_ins(TOpAddi, 5'd0, 5'd6, 16'd1);
    prog[2] = i_ins(TOpAddi, 5'd0, 5'd6, 16'd2);
    prog[3] = i_ins(TOpAddi, 5'd0, 5'd7, 16'd3);
    load_and_reset(4);
    step();
    check("beq_pc1", dut.pc_if, 32'h4);
    step();
    check("beq_pc2", dut.pc_if, 32'h8);
    step();
    check("beq_pc3_target", dut.pc_if, 32'hc);
    check("beq_ifid_flushed", dut.if_id_q.instr, 32'h0);
    step();
    check("beq_pc4", dut.pc_if, 32'h10);
    repeat (8) step();
    check("beq_r6_unchanged", dut.rf_q[6], 32'h0);
    check("beq_r7", dut.rf_q[7], 32'd3);

    // Not-taken beq: no bubbles.
    prog[0] = i_ins(TOpAddi, 5'd0, 5'd8, 16'd1);
    prog[1] = 32'h0;
    prog[2] = 32'h0;
    prog[3] = 32'h0;
    prog[4] = i_ins(TOpBeq, 5'd0, 5'd8, 16'd2);
    prog[5] = i_ins(TOpAddi, 5'd0, 5'd9, 16'd4);
    prog[6] = i_ins(TOpAddi, 5'd0, 5'd10, 16'd5);
    load_and_reset(7);
    run_until_pc(32'h20, 40, edges);
    check("bnt_edges", 32'(edges), 32'd8);
    repeat (8) step();
    check("bnt_r9", dut.rf_q[9], 32'd4);
    check("bnt_r10", dut.rf_q[10], 32'd5);

    // 18-instruction program ending in j-to-self at 0x44.
    prog[0]  = i_ins(TOpAddi, 5'd0, 5'd1, 16'd10);
    prog[1]  = i_ins(TOpAddi, 5'd0, 5'd2, 16'hfffd);
    prog[2]  = r_ins(TFnAdd, 5'd1, 5'd2, 5'd3);
    prog[3]  = r_ins(TFnSub, 5'd2, 5'd1, 5'd4);
    prog[4]  = r_ins(TFnAnd, 5'd1, 5'd3, 5'd5);
    prog[5]  = r_ins(TFnOr, 5'd1, 5'd3, 5'd6);
    prog[6]  = r_ins(TFnSlt, 5'd2, 5'd1, 5'd7);
    prog[7]  = r_ins(TFnSlt, 5'd1, 5'd2, 5'd8);
    prog[8]  = i_ins(TOpSw, 5'd0, 5'd4, 16'd4);
    prog[9]  = i_ins(TOpLw, 5'd0, 5'd9, 16'd4);
    prog[10] = r_ins(TFnAdd, 5'd9, 5'd1, 5'd10);
    prog[11] = i_ins(TOpBeq, 5'd10, 5'd2, 16'd1);
    prog[12] = i_ins(TOpAddi, 5'd0, 5'd11, 16'd99);
    prog[13] = i_ins(TOpAddi, 5'd0, 5'd12, 16'hffff);
    prog[14] = r_ins(TFnAdd, 5'd12, 5'd12, 5'd13);
    prog[15] = i_ins(TOpBeq, 5'd1, 5'd2, 16'd1);
    prog[16] = i_ins(TOpAddi, 5'd0, 5'd0, 16'd5);
    prog[17] = {TOpJ, 26'h11};
    exp_regs = '{32'h0, 32'd10, 32'hfffffffd, 32'd7, 32'hfffffff3, 32'd2, 32'd15, 32'd1,
                 32'd0, 32'hfffffff3, 32'hfffffffd, 32'h0, 32'hffffffff, 32'hfffffffe,
                 32'h0, 32'h0};
    load_and_reset(18);
    max_pc = 32'h0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (dut.pc_if > max_pc) max_pc = dut.pc_if;
    end
    check("prog_max_pc", max_pc, 32'h48);
    for (int r = 0; r < 14; r++) check($sformatf("prog_r%0d", r), dut.rf_q[r], exp_regs[r]);
    check("prog_dmem1", dut.dmem_q[1], 32'hfffffff3);

    // Reset asserted while a taken beq is in EX and a sw is in MEM.
    prog[0] = i_ins(TOpAddi, 5'd0, 5'd21, 16'd9);
    prog[1] = i_ins(TOpSw, 5'd0, 5'd0, 16'd8);
    prog[2] = i_ins(TOpBeq, 5'd0, 5'd0, 16'd3);
    load_and_reset(3);
    repeat (4) step();
    check("rst_mid_pc_before", dut.pc_if, 32'h10);
    reset_b = 1'b1;
    step();
    check("rst_mid_pc", dut.pc_if, 32'h0);
    check("rst_mid_dmem2", dut.dmem_q[2], 32'd17);
    check("rst_mid_r21", dut.rf_q[21], 32'h0);

    $display("test done: total=%0d bad=%0d", n_checks, n_errors);
    $finish;
  end

endmodule
